// File: rtl/tp_pingpong_buffer_if.sv
// Stream bundle for the ping-pong transpose buffer: row input, column output, block count.
interface tp_pingpong_buffer_if #(
    parameter int unsigned N     = 8,
    parameter int unsigned W     = 10,
    parameter int unsigned CNT_W = 16
) ();
    localparam int unsigned BW = N * W;

    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          out_first;
    logic          out_last;
    logic [CNT_W-1:0] blk_cnt;

    // Upstream/downstream environment side
    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_first, out_last, blk_cnt
    );

    // Buffer side
    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_first, out_last, blk_cnt
    );
endinterface

// File: rtl/tp_pingpong_buffer.sv
// Ping-pong N x N transpose buffer between row-DCT and column-DCT stages.
// One bank fills with rows while the other drains as columns (or rows).
module tp_pingpong_buffer #(
    parameter int unsigned N         = 8,
    parameter int unsigned W         = 10,
    parameter int unsigned TRANSPOSE = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    tp_pingpong_buffer_if.slave bus
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned RW = $clog2(N + 1);
    localparam int unsigned BW = N * W;

    // Bank storage; contents survive reset, only the bookkeeping is cleared
    logic [W-1:0]     mem [2][N][N];
    logic [1:0]       full;
    logic [RW-1:0]    rows_valid [2];
    logic             wr_sel;
    logic             rd_sel;
    logic [IW-1:0]    wr_row;
    logic [IW-1:0]    rd_beat;
    logic [CNT_W-1:0] blk_cnt;

    logic             in_ready_c;
    logic             accept_c;
    logic             row_done_c;
    logic [RW-1:0]    rows_written_c;
    logic             close_c;
    logic             out_valid_c;
    logic             xfer_c;
    logic             beat_done_c;
    logic [BW-1:0]    out_data_c;

    // Handshake decode and bank-close decision (flush counts a same-cycle beat)
    always_comb begin
        in_ready_c     = ~full[wr_sel] & ~reset;
        accept_c       = bus.in_valid & in_ready_c;
        row_done_c     = accept_c && (wr_row == IW'(N - 1));
        rows_written_c = RW'(wr_row) + (accept_c ? RW'(1) : RW'(0));
        close_c        = row_done_c | (bus.flush & in_ready_c & (rows_written_c != '0));
        out_valid_c    = full[rd_sel] & ~reset;
        xfer_c         = out_valid_c & bus.out_ready;
        beat_done_c    = xfer_c && (rd_beat == IW'(N - 1));
    end

    // Read mux: column j (transpose) or row j (pass-through), unwritten rows read as zero
    always_comb begin
        out_data_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (TRANSPOSE != 0) begin
                if (RW'(i) < rows_valid[rd_sel]) begin
                    out_data_c[i*W +: W] = mem[rd_sel][IW'(i)][rd_beat];
                end
            end else begin
                if (RW'(rd_beat) < rows_valid[rd_sel]) begin
                    out_data_c[i*W +: W] = mem[rd_sel][rd_beat][IW'(i)];
                end
            end
        end
        if (!out_valid_c) begin
            out_data_c = '0;
        end
    end

    // Row write into the filling bank
    always_ff @(posedge clk) begin
        if (accept_c) begin
            for (int unsigned c = 0; c < N; c++) begin
                mem[wr_sel][wr_row][IW'(c)] <= bus.in_data[c*W +: W];
            end
        end
    end

    // Write/read pointers, bank full flags and block counter
    always_ff @(posedge clk) begin
        if (reset) begin
            full          <= '0;
            rows_valid[0] <= '0;
            rows_valid[1] <= '0;
            wr_sel        <= 1'b0;
            rd_sel        <= 1'b0;
            wr_row        <= '0;
            rd_beat       <= '0;
            blk_cnt       <= '0;
        end else begin
            // Writer only touches a non-full bank, reader only a full one, so
            // a same-cycle close and release always hit different flags.
            if (close_c) begin
                full[wr_sel]       <= 1'b1;
                rows_valid[wr_sel] <= rows_written_c;
                wr_sel             <= ~wr_sel;
                wr_row             <= '0;
            end else if (accept_c) begin
                wr_row <= wr_row + IW'(1);
            end

            if (beat_done_c) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= ~rd_sel;
                rd_beat      <= '0;
                blk_cnt      <= blk_cnt + CNT_W'(1);
            end else if (xfer_c) begin
                rd_beat <= rd_beat + IW'(1);
            end
        end
    end

    // Output drive
    always_comb begin
        bus.in_ready  = in_ready_c;
        bus.out_valid = out_valid_c;
        bus.out_data  = out_data_c;
        bus.out_first = out_valid_c & (rd_beat == '0);
        bus.out_last  = out_valid_c & (rd_beat == IW'(N - 1));
        bus.blk_cnt   = blk_cnt;
    end

endmodule

// File: tb/tb_tp_pingpong_buffer.sv
// Bench for tp_pingpong_buffer: transpose and pass-through instances driven in lockstep.
module tb_tp_pingpong_buffer;
    localparam int N     = 8;
    localparam int W     = 10;
    localparam int CNT_W = 16;
    localparam int BW    = N * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          iv;
    logic          fl;
    logic          ordy;
    logic [BW-1:0] din;

    always #5 clk = ~clk;

    tp_pingpong_buffer_if #(.N(N), .W(W), .CNT_W(CNT_W)) bt ();
    tp_pingpong_buffer_if #(.N(N), .W(W), .CNT_W(CNT_W)) bp ();

    assign bt.in_valid  = iv;
    assign bt.in_data   = din;
    assign bt.flush     = fl;
    assign bt.out_ready = ordy;
    assign bp.in_valid  = iv;
    assign bp.in_data   = din;
    assign bp.flush     = fl;
    assign bp.out_ready = ordy;

    tp_pingpong_buffer #(.N(N), .W(W), .TRANSPOSE(1), .CNT_W(CNT_W)) dut_t (
        .clk(clk), .reset(reset), .bus(bt)
    );
    tp_pingpong_buffer #(.N(N), .W(W), .TRANSPOSE(0), .CNT_W(CNT_W)) dut_p (
        .clk(clk), .reset(reset), .bus(bp)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: rows of the open block, expected beats per mode, closed-block count
    typedef struct {
        logic [BW-1:0] d;
        bit            first;
        bit            last;
    } beat_t;

    logic [BW-1:0] cur_rows[$];
    beat_t         q_t[$];
    beat_t         q_p[$];
    int            pending = 0;
    int            blk = 0;

    task automatic chk_data(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        cur_rows.delete();
        q_t.delete();
        q_p.delete();
        pending = 0;
        blk     = 0;
    endtask

    // Close the open block: zero-pad to N rows, emit columns and rows as N beats each
    task automatic close_block();
        int            nr;
        logic [BW-1:0] rw;
        beat_t         b_t;
        beat_t         b_p;
        nr = cur_rows.size();
        for (int j = 0; j < N; j++) begin
            b_t.d = '0;
            b_p.d = '0;
            for (int i = 0; i < nr; i++) begin
                rw = cur_rows[i];
                b_t.d[i*W +: W] = rw[j*W +: W];
            end
            if (j < nr) b_p.d = cur_rows[j];
            b_t.first = (j == 0);
            b_t.last  = (j == N - 1);
            b_p.first = b_t.first;
            b_p.last  = b_t.last;
            q_t.push_back(b_t);
            q_p.push_back(b_p);
        end
        cur_rows.delete();
        pending++;
    endtask

    // One cycle: compare at the falling edge, then advance the model at the rising edge
    task automatic step();
        bit    eir;
        bit    eov;
        beat_t et;
        beat_t ep;
        beat_t b;
        @(negedge clk);
        eir = !reset && (pending < 2);
        eov = !reset && (pending > 0);
        et  = '{d: '0, first: 1'b0, last: 1'b0};
        ep  = et;
        if (eov) begin
            et = q_t[0];
            ep = q_p[0];
        end
        chk_bit("t_in_ready", bt.in_ready, eir);
        chk_bit("p_in_ready", bp.in_ready, eir);
        chk_bit("t_out_valid", bt.out_valid, eov);
        chk_bit("p_out_valid", bp.out_valid, eov);
        chk_data("t_out_data", bt.out_data, et.d);
        chk_data("p_out_data", bp.out_data, ep.d);
        chk_bit("t_out_first", bt.out_first, et.first);
        chk_bit("p_out_first", bp.out_first, ep.first);
        chk_bit("t_out_last", bt.out_last, et.last);
        chk_bit("p_out_last", bp.out_last, ep.last);
        chk_int("t_blk_cnt", int'(bt.blk_cnt), blk);
        chk_int("p_blk_cnt", int'(bp.blk_cnt), blk);
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            if (iv && eir) cur_rows.push_back(din);
            if (cur_rows.size() == N) close_block();
            else if (fl && eir && cur_rows.size() > 0) close_block();
            if (eov && ordy) begin
                b = q_t.pop_front();
                void'(q_p.pop_front());
                if (b.last) begin
                    pending--;
                    blk = (blk + 1) % (1 << CNT_W);
                end
            end
        end
        #1;
    endtask

    function automatic logic [BW-1:0] mkrow(input int r, input int off);
        logic [BW-1:0] res;
        res = '0;
        for (int c = 0; c < N; c++) res[c*W +: W] = W'(r * N + c + off);
        return res;
    endfunction

    // Expected beat for the directed table: element values are row*N+col+off
    function automatic logic [BW-1:0] tbl_exp(input bit tr, input int beat, input int rows, input int off);
        logic [BW-1:0] res;
        int            v;
        res = '0;
        if (beat >= 0) begin
            for (int i = 0; i < N; i++) begin
                if (tr) v = (i < rows) ? i * N + beat + off : 0;
                else    v = (beat < rows) ? beat * N + i + off : 0;
                res[i*W +: W] = W'(v);
            end
        end
        return res;
    endfunction

    typedef struct {
        bit v;
        bit f;
        bit r;
        int row;
        int off;
        bit e_ir;
        bit e_ov;
        int e_beat;
        int e_rows;
        int e_off;
        int e_blk;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit v, input bit f, input bit r, input int row, input int off,
                       input bit e_ov, input int e_beat, input int e_rows, input int e_off,
                       input int e_blk);
        vec_t x;
        x = '{v: v, f: f, r: r, row: row, off: off, e_ir: 1'b1, e_ov: e_ov,
              e_beat: e_beat, e_rows: e_rows, e_off: e_off, e_blk: e_blk};
        tbl.push_back(x);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        iv    = 1'b0;
        fl    = 1'b0;
        for (int k = 0; k < cycles; k++) step();
        reset = 1'b0;
    endtask

    int cnt_ir;
    int cnt_ov;

    initial begin
        reset = 1'b1;
        iv    = 1'b0;
        fl    = 1'b0;
        ordy  = 1'b0;
        din   = '0;
        @(posedge clk);
        @(posedge clk);
        model_clear();
        #1;
        // Reset state observed while reset is still held
        do_reset(2);

        // Directed table: full block, flush partial, idle flush, flush on last row
        for (int r = 0; r < N; r++) add(1, 0, 1, r, 0, 0, -1, 0, 0, 0);
        for (int j = 0; j < N; j++) add(0, 0, 1, -1, 0, 1, j, N, 0, 0);
        add(0, 0, 1, -1, 0, 0, -1, 0, 0, 1);
        for (int r = 0; r < 3; r++) add(1, 0, 1, r, 1, 0, -1, 0, 0, 1);
        add(0, 1, 1, -1, 0, 0, -1, 0, 0, 1);
        for (int j = 0; j < N; j++) add(0, 0, 1, -1, 0, 1, j, 3, 1, 1);
        add(0, 1, 1, -1, 0, 0, -1, 0, 0, 2);
        add(0, 0, 1, -1, 0, 0, -1, 0, 0, 2);
        for (int r = 0; r < N; r++) add(1, 0, 1, r, 100, 0, -1, 0, 0, 2);
        for (int j = 0; j < N; j++) add(0, 0, 1, -1, 0, 1, j, N, 100, 2);
        for (int r = 0; r < N; r++) add(1, (r == N - 1), 1, r, 200, 0, -1, 0, 0, 3);
        for (int j = 0; j < N; j++) add(0, 0, 1, -1, 0, 1, j, N, 200, 3);
        add(0, 0, 1, -1, 0, 0, -1, 0, 0, 4);
        add(0, 0, 1, -1, 0, 0, -1, 0, 0, 4);

        foreach (tbl[k]) begin
            iv   = tbl[k].v;
            fl   = tbl[k].f;
            ordy = tbl[k].r;
            din  = (tbl[k].row >= 0) ? mkrow(tbl[k].row, tbl[k].off) : '0;
            #2;
            chk_bit("tbl_in_ready", bt.in_ready, tbl[k].e_ir);
            chk_bit("tbl_out_valid", bt.out_valid, tbl[k].e_ov);
            chk_data("tbl_t_data", bt.out_data, tbl_exp(1'b1, tbl[k].e_beat, tbl[k].e_rows, tbl[k].e_off));
            chk_data("tbl_p_data", bp.out_data, tbl_exp(1'b0, tbl[k].e_beat, tbl[k].e_rows, tbl[k].e_off));
            chk_bit("tbl_first", bt.out_first, tbl[k].e_beat == 0);
            chk_bit("tbl_last", bt.out_last, tbl[k].e_beat == N - 1);
            chk_int("tbl_blk_cnt", int'(bt.blk_cnt), tbl[k].e_blk);
            step();
        end

        // Back-to-back: 4 blocks streamed, no input stall, 32 contiguous output beats
        do_reset(1);
        ordy   = 1'b1;
        cnt_ir = 0;
        cnt_ov = 0;
        for (int k = 0; k < 4 * N + 10; k++) begin
            iv  = (k < 4 * N);
            fl  = 1'b0;
            din = BW'({$urandom(), $urandom(), $urandom()});
            #2;
            if (k < 4 * N && bt.in_ready) cnt_ir++;
            if (k >= N && k < 5 * N && bt.out_valid) cnt_ov++;
            step();
        end
        chk_int("b2b_in_ready_cycles", cnt_ir, 4 * N);
        chk_int("b2b_out_beats", cnt_ov, 4 * N);
        chk_int("b2b_blk_cnt", int'(bt.blk_cnt), 4);

        // Backpressure: both banks fill, input stalls, then drain intact
        do_reset(1);
        ordy   = 1'b0;
        cnt_ir = 0;
        for (int k = 0; k < 2 * N + 4; k++) begin
            iv  = 1'b1;
            din = BW'({$urandom(), $urandom(), $urandom()});
            #2;
            if (bt.in_ready) cnt_ir++;
            step();
        end
        chk_int("bp_accepted_rows", cnt_ir, 2 * N);
        chk_bit("bp_in_ready_stalled", bt.in_ready, 1'b0);
        iv = 1'b0;
        for (int k = 0; k < 2 * N + 2; k++) begin
            ordy = (k % 3) != 1;
            step();
        end
        ordy = 1'b1;
        for (int k = 0; k < 12; k++) step();
        chk_int("bp_blk_cnt", int'(bt.blk_cnt), 2);

        // Reset mid-block discards partial rows
        do_reset(1);
        for (int k = 0; k < 5; k++) begin
            iv  = 1'b1;
            din = mkrow(k, 500);
            step();
        end
        do_reset(2);
        chk_bit("rst_out_valid", bt.out_valid, 1'b0);
        chk_int("rst_blk_cnt", int'(bt.blk_cnt), 0);
        for (int k = 0; k < 2 * N + 2; k++) begin
            iv  = (k < N);
            din = mkrow(k, 7);
            step();
        end
        chk_int("rst_blk_after", int'(bt.blk_cnt), 1);

        // Randomized traffic with flushes, backpressure and occasional resets
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 299) == 0);
            iv    = ($urandom_range(0, 3) != 0);
            fl    = ($urandom_range(0, 11) == 0);
            ordy  = (k % 500 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            din   = BW'({$urandom(), $urandom(), $urandom()});
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tp_pingpong_buffer.md
Name: tp_pingpong_buffer

Overview:
Parametrised ping-pong transpose buffer sitting between row-DCT and column-DCT stages of the 2D DCT pipeline. It accepts N-element rows on a valid/ready stream and emits N-element columns of each completed N×N block. It replaces the fixed counter-timed TPmem pair with backpressure, selectable transpose/pass-through, and zero-padded partial-block flush.

Parameters:
N, 8, block dimension (rows per block, elements per beat); legal values 2..16
W, 10, element width in bits
TRANSPOSE, 1, 1 = output columns (transpose); 0 = output rows in arrival order
CNT_W, 16, width of blk_cnt

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  buffer can accept a beat
in_data  in  N*W  row; element c at bits [c*W +: W], element 0 at LSB
flush  in  1  close current partial block, zero-padded
out_valid  out  1  output beat valid
out_ready  in  1  sink accepts beat
out_data  out  N*W  output beat, same packing as in_data
out_first  out  1  beat index 0 of a block (qualified by out_valid)
out_last  out  1  beat index N-1 of a block (qualified by out_valid)
blk_cnt  out  CNT_W  count of blocks fully emitted

Behaviour:
- Storage: two banks B0/B1, each N×N×W registers, plus per-bank full flag and rows_valid (0..N).
- Write side: wr_sel (bank), wr_row (0..N-1). in_ready = !full[wr_sel] and !reset.
- Accept (in_valid & in_ready): bank[wr_sel][wr_row][c] <= element c. If wr_row==N-1: full[wr_sel]<=1, rows_valid<=N, wr_sel toggles, wr_row<=0; else wr_row++.
- Flush: sampled only when in_ready=1. If wr_row!=0 (after counting a same-cycle accepted beat): bank closed with rows_valid = rows written, full set, wr_sel toggles, wr_row<=0. Flush with wr_row==0 and no accept: no effect. Flush on the same cycle a beat completes row N-1: no extra effect. Flush while in_ready=0: ignored; source holds it.
- Read side: rd_sel, rd_beat (0..N-1). out_valid = full[rd_sel]. Combinational read from bank registers.
- TRANSPOSE=1: beat j element i = bank[rd_sel][i][j]; element i forced 0 if i >= rows_valid.
- TRANSPOSE=0: beat j = row j; whole beat forced 0 if j >= rows_valid.
- out_data = 0 whenever out_valid=0. out_first = (rd_beat==0), out_last = (rd_beat==N-1), both 0 when out_valid=0.
- Transfer (out_valid & out_ready): rd_beat++; at N-1: full[rd_sel]<=0, rd_sel toggles, rd_beat<=0, blk_cnt++ (wraps modulo 2^CNT_W). Partial blocks always emit N beats.
- Simultaneous write-close of one bank and read-release of the other in the same cycle: both take effect. Write and read never target the same full bank (write requires !full, read requires full).
- Latency: out_valid rises the cycle after the accept completing a block (or effective flush). Sustained throughput 1 beat/cycle both sides with out_ready=1; no bubbles between blocks.
- Backpressure: out_data/out_first/out_last stable while out_valid & !out_ready. With both banks full, in_ready=0 until one bank drains.
- Reset (any cycle, including mid-block): full flags, wr_sel, rd_sel, wr_row, rd_beat, rows_valid, blk_cnt <= 0. out_valid=0 and in_ready=0 while reset is high; in_ready=1 on the first cycle after release. Bank contents are not cleared. Partial data is discarded.

Test Plan:
- N=8, W=10, TRANSPOSE=1, in_data row r element c = r*8+c, in_valid=1, out_ready=1 for 8 beats -> out_valid 1 cycle after 8th accept; beat j element i = i*8+j; out_first on beat 0, out_last on beat 7; blk_cnt=1.
- Stream 4 blocks back-to-back with out_ready=1 -> in_ready never drops, output continuous 32 beats, blk_cnt=4.
- out_ready=0 with 16 rows sent -> in_ready=0 after 16th accept, 17th beat stalled; release out_ready -> block0 then block1 emitted intact, out_data stable while stalled.
- Send 3 rows (values 1..24), assert flush -> 8 output beats; beat j elements 0..2 = row data, elements 3..7 = 0; next block is written to the other bank from wr_row 0.
- TRANSPOSE=0, same stimulus as first scenario -> beat j equals input row j unchanged.
- Assert reset after 5 rows of block0 -> out_valid=0, blk_cnt=0; 8 fresh rows after release produce one correct block with no residue of the 5 discarded rows.
